// File: rtl/pwm_multi_timer_pkg.sv
// Shared types and constants for the multi-channel PWM timer.
package pwm_multi_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/pwm_multi_timer_if.sv
// Control/status bundle between the register interface and the PWM timer.
interface pwm_multi_timer_if #(
  parameter int BITS       = 8,
  parameter int CHANNELS   = 2,
  parameter int PRESC_BITS = 4
);

  logic                     enable;
  logic                     mode;
  logic                     start;
  logic                     stop;
  logic                     update;
  logic [PRESC_BITS-1:0]    prescale;
  logic [BITS-1:0]          final_value;
  logic [CHANNELS*BITS-1:0] duty;
  logic [CHANNELS-1:0]      pwm_out;
  logic                     done;
  logic                     busy;
  logic [BITS-1:0]          count;

  modport master (
    output enable, mode, start, stop, update, prescale, final_value, duty,
    input  pwm_out, done, busy, count
  );

  modport slave (
    input  enable, mode, start, stop, update, prescale, final_value, duty,
    output pwm_out, done, busy, count
  );

endinterface

// File: rtl/pwm_compare_channel.sv
// One PWM compare output: double-buffered duty register and registered comparator.
module pwm_compare_channel #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            update,
  input  logic            load,
  input  logic            run_next,
  input  logic [BITS-1:0] duty_in,
  input  logic [BITS-1:0] count_next,
  output logic            pwm
);

  logic [BITS-1:0] duty_sh;
  logic [BITS-1:0] duty_act;
  logic [BITS-1:0] duty_act_next;

  assign duty_act_next = load ? duty_sh : duty_act;

  // Compare against next-cycle values so the output lines up with the count it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh  <= '0;
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      if (update) duty_sh <= duty_in;
      duty_act <= duty_act_next;
      pwm      <= run_next & (count_next < duty_act_next);
    end
  end

endmodule

// File: rtl/pwm_multi_timer.sv
// Prescaled up-counter with run/idle control driving CHANNELS buffered PWM compare outputs.
module pwm_multi_timer
  import pwm_multi_timer_pkg::*;
#(
  parameter int BITS       = 8,
  parameter int CHANNELS   = 2,
  parameter int PRESC_BITS = 4
) (
  input logic               clk,
  input logic               rst_n,
  pwm_multi_timer_if.slave  bus
);

  state_t                state, state_nx;
  logic [PRESC_BITS-1:0] psc, psc_nx;
  logic [BITS-1:0]       count_r, count_nx;
  logic                  done_r, done_nx;
  logic                  mode_act;
  logic [BITS-1:0]       final_sh, final_act;
  logic [PRESC_BITS-1:0] presc_sh, presc_act;
  logic                  pending;
  logic                  start_go;
  logic                  tick;
  logic                  term;
  logic                  load;
  logic [CHANNELS-1:0]   pwm;

  assign start_go = bus.start & ~bus.stop;
  assign tick     = (state == RUN) & bus.enable & (psc == presc_act);
  assign term     = tick & (count_r == final_act);
  // Buffered values only reach the active set at a period boundary, so the counter never overruns final_act.
  assign load     = pending & ((state == IDLE) | start_go | term);

  always_comb begin
    state_nx = state;
    psc_nx   = psc;
    count_nx = count_r;
    done_nx  = 1'b0;
    if (bus.stop) begin
      state_nx = IDLE;
      psc_nx   = '0;
      count_nx = '0;
    end else if (bus.start) begin
      state_nx = RUN;
      psc_nx   = '0;
      count_nx = '0;
    end else if (tick) begin
      psc_nx = '0;
      if (term) begin
        count_nx = '0;
        done_nx  = 1'b1;
        if (mode_act == MODE_ONESHOT) state_nx = IDLE;
      end else begin
        count_nx = count_r + BITS'(1);
      end
    end else if ((state == RUN) && bus.enable) begin
      psc_nx = psc + PRESC_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      psc       <= '0;
      count_r   <= '0;
      done_r    <= 1'b0;
      mode_act  <= MODE_PERIODIC;
      final_sh  <= '0;
      final_act <= '0;
      presc_sh  <= '0;
      presc_act <= '0;
      pending   <= 1'b0;
    end else begin
      state   <= state_nx;
      psc     <= psc_nx;
      count_r <= count_nx;
      done_r  <= done_nx;
      if (start_go) mode_act <= bus.mode;
      if (load) begin
        final_act <= final_sh;
        presc_act <= presc_sh;
      end
      // A capture coinciding with a load keeps the new values pending for the next boundary.
      if (bus.update) begin
        final_sh <= bus.final_value;
        presc_sh <= bus.prescale;
        pending  <= 1'b1;
      end else if (load) begin
        pending <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_compare_channel #(.BITS(BITS)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .update     (bus.update),
      .load       (load),
      .run_next   (state_nx == RUN),
      .duty_in    (bus.duty[i*BITS +: BITS]),
      .count_next (count_nx),
      .pwm        (pwm[i])
    );
  end

  assign bus.pwm_out = pwm;
  assign bus.done    = done_r;
  assign bus.busy    = (state == RUN);
  assign bus.count   = count_r;

endmodule

// File: tb/tb_pwm_multi_timer.sv
// Bench for pwm_multi_timer: directed scenarios plus random traffic against a period-phase model.
module tb_pwm_multi_timer;
  localparam int BITS = 8;
  localparam int CH   = 2;
  localparam int PB   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_multi_timer_if #(.BITS(BITS), .CHANNELS(CH), .PRESC_BITS(PB)) bus ();

  pwm_multi_timer #(.BITS(BITS), .CHANNELS(CH), .PRESC_BITS(PB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: the timer is described by how many clocks have elapsed in the current period.
  bit m_run, m_one, m_pend, m_done;
  int m_ph, m_fin, m_pre, s_fin, s_pre;
  int m_duty[CH];
  int s_duty[CH];

  int t1_cnt[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int t1_pwm0[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
  int t1_done[8] = '{0, 0, 0, 0, 1, 0, 0, 0};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_one = 0; m_pend = 0; m_done = 0;
    m_ph = 0; m_fin = 0; m_pre = 0; s_fin = 0; s_pre = 0;
    for (int i = 0; i < CH; i++) begin
      m_duty[i] = 0;
      s_duty[i] = 0;
    end
  endtask

  task automatic model_step();
    int  last;
    bit  term, go, ld;
    if (!rst_n) begin
      model_reset();
      return;
    end
    last = (m_fin + 1) * (m_pre + 1) - 1;
    term = m_run && bus.enable && (m_ph == last);
    go   = bus.start && !bus.stop;
    ld   = m_pend && (!m_run || go || term);
    m_done = 0;
    if (bus.stop) begin
      m_run = 0; m_ph = 0;
    end else if (bus.start) begin
      m_run = 1; m_ph = 0; m_one = bus.mode;
    end else if (m_run && bus.enable) begin
      if (term) begin
        m_ph = 0; m_done = 1;
        if (m_one) m_run = 0;
      end else begin
        m_ph++;
      end
    end
    if (ld) begin
      m_fin = s_fin; m_pre = s_pre;
      for (int i = 0; i < CH; i++) m_duty[i] = s_duty[i];
    end
    if (bus.update) begin
      s_fin = int'(bus.final_value);
      s_pre = int'(bus.prescale);
      for (int i = 0; i < CH; i++) s_duty[i] = int'(bus.duty[i*BITS +: BITS]);
      m_pend = 1;
    end else if (ld) begin
      m_pend = 0;
    end
  endtask

  task automatic compare();
    int ec;
    int ep;
    ec = m_run ? m_ph / (m_pre + 1) : 0;
    ep = 0;
    for (int i = 0; i < CH; i++)
      if (m_run && ec < m_duty[i]) ep |= (1 << i);
    chk("count",   int'(bus.count),   ec);
    chk("busy",    int'(bus.busy),    int'(m_run));
    chk("done",    int'(bus.done),    int'(m_done));
    chk("pwm_out", int'(bus.pwm_out), ep);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic configure(input int pre, input int fin, input int d0, input int d1);
    bus.prescale    = PB'(pre);
    bus.final_value = BITS'(fin);
    bus.duty        = {BITS'(d1), BITS'(d0)};
    bus.update      = 1'b1;
    cyc();
    bus.update      = 1'b0;
  endtask

  task automatic pulse_start(input bit md);
    bus.mode  = md;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
  endtask

  initial begin
    int n;
    bus.enable = 1'b1; bus.mode = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    bus.update = 1'b0; bus.prescale = '0; bus.final_value = '0; bus.duty = '0;
    model_reset();

    #12;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_busy",  int'(bus.busy), 0);
    chk("rst_done",  int'(bus.done), 0);
    chk("rst_pwm",   int'(bus.pwm_out), 0);
    rst_n = 1'b1;
    cyc();

    // 1: presc 0, final 3, duty 2/0, periodic
    configure(0, 3, 2, 0);
    cyc();
    pulse_start(1'b0);
    for (int k = 0; k < 8; k++) begin
      chk("t1_count", int'(bus.count), t1_cnt[k]);
      chk("t1_pwm0",  int'(bus.pwm_out[0]), t1_pwm0[k]);
      chk("t1_pwm1",  int'(bus.pwm_out[1]), 0);
      chk("t1_done",  int'(bus.done), t1_done[k]);
      cyc();
    end

    // 2: presc 2, final 4 -> done every 15 clocks
    pulse_stop();
    configure(2, 4, 2, 0);
    cyc();
    pulse_start(1'b0);
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (k == 3) chk("t2_count_k3", int'(bus.count), 1);
      if (bus.done) n++;
    end
    chk("t2_dones", n, 2);

    // 3: one-shot, final 5
    pulse_stop();
    configure(0, 5, 3, 0);
    cyc();
    pulse_start(1'b1);
    bus.mode = 1'b0;
    for (int k = 1; k <= 6; k++) cyc();
    chk("t3_done", int'(bus.done), 1);
    chk("t3_busy", int'(bus.busy), 0);
    chk("t3_count", int'(bus.count), 0);
    chk("t3_pwm", int'(bus.pwm_out), 0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (bus.done) n++;
    end
    chk("t3_extra_dones", n, 0);

    // 4: update mid-period takes effect at the next boundary
    configure(0, 3, 2, 0);
    cyc();
    pulse_start(1'b0);
    cyc();
    bus.final_value = BITS'(7);
    bus.duty        = {BITS'(0), BITS'(1)};
    bus.update      = 1'b1;
    cyc();
    bus.update      = 1'b0;
    chk("t4_old_count", int'(bus.count), 2);
    chk("t4_old_pwm0", int'(bus.pwm_out[0]), 0);
    cyc();
    cyc();
    chk("t4_boundary_done", int'(bus.done), 1);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.pwm_out[0]) n++;
      if (k == 7) chk("t4_count7", int'(bus.count), 7);
      if (k < 7) cyc();
    end
    chk("t4_pwm0_high", n, 1);

    // 5: duty above final -> constant high, then stop
    pulse_stop();
    configure(0, 8, 9, 0);
    cyc();
    pulse_start(1'b0);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.pwm_out[0]) n++;
      cyc();
    end
    chk("t5_pwm0_high", n, 12);
    pulse_stop();
    chk("t5_stop_pwm0", int'(bus.pwm_out[0]), 0);
    chk("t5_stop_busy", int'(bus.busy), 0);
    chk("t5_stop_count", int'(bus.count), 0);

    // 6: enable freeze, then asynchronous reset
    configure(0, 7, 4, 0);
    cyc();
    pulse_start(1'b0);
    for (int k = 0; k < 3; k++) cyc();
    bus.enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t6_frz_count", int'(bus.count), 3);
      chk("t6_frz_done", int'(bus.done), 0);
      chk("t6_frz_pwm0", int'(bus.pwm_out[0]), 1);
    end
    bus.enable = 1'b1;
    cyc();
    chk("t6_resume_count", int'(bus.count), 4);
    cyc();
    rst_n = 1'b0;
    #2;
    chk("t6_arst_count", int'(bus.count), 0);
    chk("t6_arst_busy", int'(bus.busy), 0);
    chk("t6_arst_pwm", int'(bus.pwm_out), 0);
    model_reset();
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    chk("t6_idle_after_rst", int'(bus.busy), 0);
    configure(0, 3, 1, 3);
    pulse_start(1'b0);
    chk("t6_restart_busy", int'(bus.busy), 1);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      bus.enable      = ($urandom_range(0, 9) != 0);
      bus.start       = ($urandom_range(0, 59) == 0);
      bus.stop        = ($urandom_range(0, 99) == 0);
      bus.mode        = 1'($urandom_range(0, 1));
      bus.update      = ($urandom_range(0, 14) == 0);
      bus.prescale    = PB'($urandom_range(0, 3));
      bus.final_value = BITS'($urandom_range(0, 12));
      bus.duty        = {BITS'($urandom_range(0, 14)), BITS'($urandom_range(0, 14))};
      cyc();
    end
    bus.start = 1'b0; bus.stop = 1'b0; bus.update = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
